rr_hold_arbiter: RTL and testbench

- Parametrised successor to the fixed-priority arbiter: N-port arbiter with a registered one-hot grant.
- Run-time selectable policy: fixed priority (port 0 highest) or round robin.
- Bounded grant tenure: an owner keeps the grant while it requests, up to MAX_HOLD cycles, then must re-arbitrate.
- Sits in front of shared resources (bus, memory port) where fairness and burst locality both matter.

---
 rtl/rr_hold_arbiter_pkg.sv | 29 ++
 rtl/rr_hold_arbiter_prio_select.sv | 26 ++
 rtl/rr_hold_arbiter.sv | 110 +++++++++++
 tb/tb_rr_hold_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_hold_arbiter_pkg.sv
// arb_pkg: shared types and helpers for the rr_hold_arbiter slice.
//   arb_mode_e    - arbitration policy selector (fixed priority / round robin)
//   clog2_min1    - ceil(log2(value)) but never below 1, for index/counter widths
//   onehot_to_idx - binary index of the highest set bit of a one-hot vector
//                   (0 for an all-zero vector)
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Widest vector onehot_to_idx accepts; callers zero-extend into it.
  localparam int IDX_VEC_W = 64;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic int onehot_to_idx(input logic [IDX_VEC_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < IDX_VEC_W; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_hold_arbiter_prio_select.sv
// prio_select: combinational lowest-index-first selector.
//   req - request vector, bit i = port i requests
//   gnt - one-hot grant to the lowest-index requester, zero when req is zero
//   any - high when at least one request is present
module prio_select #(
  parameter int NUM_PORTS = 5
) (
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    gnt = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: N-port arbiter with a registered one-hot grant, run-time
// selectable fixed-priority / round-robin policy and bounded grant tenure.
//   clk_i       - clock, rising edge
//   rst_ni      - asynchronous active-low reset
//   req_i       - request vector, bit i = port i requests
//   mode_i      - 0 = fixed priority (port 0 highest), 1 = round robin
//   gnt_o       - registered one-hot grant, zero when idle
//   gnt_id_o    - binary index of the granted port, zero when idle
//   gnt_valid_o - high whenever gnt_o is non-zero
// NUM_PORTS must not exceed arb_pkg::IDX_VEC_W.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 4,
  parameter int ID_W      = clog2_min1(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 mode_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 gnt_valid_o
);

  localparam int CNT_W = clog2_min1(MAX_HOLD + 1);

  arb_mode_e            mode;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [ID_W-1:0]      id_q;
  logic [ID_W-1:0]      ptr_q;
  logic [CNT_W-1:0]     hold_q;

  logic [NUM_PORTS-1:0] ptr_mask;
  logic [NUM_PORTS-1:0] masked_req;
  logic [NUM_PORTS-1:0] fixed_gnt;
  logic [NUM_PORTS-1:0] masked_gnt;
  logic [NUM_PORTS-1:0] next_gnt;
  logic                 fixed_any;
  logic                 masked_any;
  logic                 hold;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      next_ptr;

  assign mode = arb_mode_e'(mode_i);

  // The tenure continues only while the owner keeps requesting and has cycles
  // left; the mode input is deliberately ignored here so a policy change
  // never cuts a running tenure short.
  assign hold = (|(req_i & gnt_q)) && (hold_q < CNT_W'(MAX_HOLD - 1));

  // Ports at or above the pointer get first pick in round-robin mode.
  always_comb begin
    ptr_mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ptr_mask[i] = (i >= int'(ptr_q));
    end
  end

  assign masked_req = req_i & ptr_mask;

  prio_select #(.NUM_PORTS(NUM_PORTS)) u_fixed_sel (
    .req (req_i),
    .gnt (fixed_gnt),
    .any (fixed_any)
  );

  prio_select #(.NUM_PORTS(NUM_PORTS)) u_masked_sel (
    .req (masked_req),
    .gnt (masked_gnt),
    .any (masked_any)
  );

  // The unmasked lowest-index pick doubles as the wrap-around fallback for
  // round robin when nothing at or above the pointer is requesting.
  always_comb begin
    next_gnt = fixed_gnt;
    if (mode == ARB_RR && masked_any) begin
      next_gnt = masked_gnt;
    end
  end

  assign win_idx  = ID_W'(onehot_to_idx(IDX_VEC_W'(next_gnt)));
  assign next_ptr = (win_idx == ID_W'(NUM_PORTS - 1)) ? '0 : win_idx + ID_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q  <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
      hold_q <= '0;
    end else if (hold) begin
      hold_q <= hold_q + CNT_W'(1);
    end else begin
      gnt_q  <= next_gnt;
      id_q   <= win_idx;
      hold_q <= '0;
      // Re-granting the same owner after expiry still counts as a new tenure.
      if (mode == ARB_RR && fixed_any) begin
        ptr_q <= next_ptr;
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = id_q;
  assign gnt_valid_o = |gnt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed self-checking bench for rr_hold_arbiter.
// Three instances share clock, reset and requests:
//   dut    - NUM_PORTS = 5, MAX_HOLD = 4
//   dut_h1 - NUM_PORTS = 5, MAX_HOLD = 1
//   dut_p1 - NUM_PORTS = 1, driven by req[0]
module tb_rr_hold_arbiter;

  typedef struct {
    bit         do_reset;
    logic [4:0] req;
    logic       mode;
    logic [4:0] exp_gnt;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic       mode;

  logic [4:0] gnt_a;
  logic [2:0] id_a;
  logic       val_a;
  logic [4:0] gnt_h;
  logic [2:0] id_h;
  logic       val_h;
  logic [0:0] gnt_p;
  logic [0:0] id_p;
  logic       val_p;

  int checks = 0;
  int fails  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_hold_arbiter #(.NUM_PORTS(5), .MAX_HOLD(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .mode_i(mode),
    .gnt_o(gnt_a), .gnt_id_o(id_a), .gnt_valid_o(val_a)
  );

  rr_hold_arbiter #(.NUM_PORTS(5), .MAX_HOLD(1)) dut_h1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .mode_i(mode),
    .gnt_o(gnt_h), .gnt_id_o(id_h), .gnt_valid_o(val_h)
  );

  rr_hold_arbiter #(.NUM_PORTS(1), .MAX_HOLD(4)) dut_p1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0:0]), .mode_i(mode),
    .gnt_o(gnt_p), .gnt_id_o(id_p), .gnt_valid_o(val_p)
  );

  // Drive inputs, then move to 1 time unit past the next rising edge.
  task automatic apply_stimulus(input logic [4:0] r, input logic m);
    req  = r;
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expected id and valid are derived from the expected grant vector.
  task automatic check_output(input string name, input logic [4:0] exp_gnt,
                              input logic [4:0] act_gnt, input logic [2:0] act_id,
                              input logic act_valid);
    logic [2:0] exp_id;
    logic       exp_valid;
    exp_id    = '0;
    exp_valid = |exp_gnt;
    for (int i = 0; i < 5; i++) if (exp_gnt[i]) exp_id = 3'(i);
    checks++;
    if (act_gnt !== exp_gnt) begin
      fails++;
      $display("[TB] FAIL %s gnt: got %b, expected %b", name, act_gnt, exp_gnt);
    end
    checks++;
    if (act_id !== exp_id) begin
      fails++;
      $display("[TB] FAIL %s gnt_id: got %0d, expected %0d", name, act_id, exp_id);
    end
    checks++;
    if (act_valid !== exp_valid) begin
      fails++;
      $display("[TB] FAIL %s gnt_valid: got %b, expected %b", name, act_valid, exp_valid);
    end
  endtask

  task automatic add_vec(input bit rst, input logic [4:0] r, input logic m,
                         input logic [4:0] e, input string n);
    vec_t v;
    v.do_reset = rst;
    v.req      = r;
    v.mode     = m;
    v.exp_gnt  = e;
    v.name     = n;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] rot_exp [6];

    // Idle: nothing requested after reset.
    add_vec(1, 5'b00000, 1'b1, 5'b00000, "idle0");
    add_vec(0, 5'b00000, 1'b1, 5'b00000, "idle1");
    add_vec(0, 5'b00000, 1'b1, 5'b00000, "idle2");
    // Tenure limit in round robin: four cycles each, then back to port 0.
    add_vec(1, 5'b00011, 1'b1, 5'b00001, "ten_p0_c0");
    add_vec(0, 5'b00011, 1'b1, 5'b00001, "ten_p0_c1");
    add_vec(0, 5'b00011, 1'b1, 5'b00001, "ten_p0_c2");
    add_vec(0, 5'b00011, 1'b1, 5'b00001, "ten_p0_c3");
    add_vec(0, 5'b00011, 1'b1, 5'b00010, "ten_p1_c0");
    add_vec(0, 5'b00011, 1'b1, 5'b00010, "ten_p1_c1");
    add_vec(0, 5'b00011, 1'b1, 5'b00010, "ten_p1_c2");
    add_vec(0, 5'b00011, 1'b1, 5'b00010, "ten_p1_c3");
    add_vec(0, 5'b00011, 1'b1, 5'b00001, "ten_wrap");
    // Fixed priority: owner drop hands over with no idle cycle.
    add_vec(1, 5'b10100, 1'b0, 5'b00100, "fix_p2");
    add_vec(0, 5'b10000, 1'b0, 5'b10000, "fix_handover");
    // Fixed priority after tenure expiry goes back to the lowest requester.
    add_vec(1, 5'b00011, 1'b0, 5'b00001, "fixexp_c0");
    add_vec(0, 5'b00011, 1'b0, 5'b00001, "fixexp_c1");
    add_vec(0, 5'b00011, 1'b0, 5'b00001, "fixexp_c2");
    add_vec(0, 5'b00011, 1'b0, 5'b00001, "fixexp_c3");
    add_vec(0, 5'b00011, 1'b0, 5'b00001, "fixexp_regrant");
    // Sole requester: no bubble at expiry, pointer ends at 4.
    for (int i = 0; i < 10; i++) add_vec(i == 0, 5'b01000, 1'b1, 5'b01000, $sformatf("sole_%0d", i));
    add_vec(0, 5'b00000, 1'b1, 5'b00000, "sole_idle");
    add_vec(0, 5'b11111, 1'b1, 5'b10000, "sole_ptr4");
    add_vec(0, 5'b11111, 1'b1, 5'b10000, "p4_hold1");
    add_vec(0, 5'b11111, 1'b1, 5'b10000, "p4_hold2");
    add_vec(0, 5'b11111, 1'b1, 5'b10000, "p4_hold3");
    add_vec(0, 5'b11111, 1'b1, 5'b00001, "p4_wrap");
    // Mode switching: pointer frozen in fixed mode, tenure not cut short.
    add_vec(1, 5'b00001, 1'b1, 5'b00001, "mode_rr_p0");
    add_vec(0, 5'b00000, 1'b1, 5'b00000, "mode_idle");
    add_vec(0, 5'b00110, 1'b0, 5'b00010, "mode_fix_p1");
    add_vec(0, 5'b00110, 1'b1, 5'b00010, "mode_hold1");
    add_vec(0, 5'b00110, 1'b1, 5'b00010, "mode_hold2");
    add_vec(0, 5'b00110, 1'b1, 5'b00010, "mode_hold3");
    add_vec(0, 5'b00110, 1'b1, 5'b00010, "mode_ptr_kept");
    add_vec(0, 5'b00110, 1'b1, 5'b00010, "mode_hold4");
    add_vec(0, 5'b00110, 1'b1, 5'b00010, "mode_hold5");
    add_vec(0, 5'b00110, 1'b1, 5'b00010, "mode_hold6");
    add_vec(0, 5'b00110, 1'b1, 5'b00100, "mode_rr_p2");
    add_vec(0, 5'b00110, 1'b0, 5'b00100, "mode_nocut1");
    add_vec(0, 5'b00110, 1'b0, 5'b00100, "mode_nocut2");
    add_vec(0, 5'b00110, 1'b0, 5'b00100, "mode_nocut3");
    add_vec(0, 5'b00110, 1'b0, 5'b00010, "mode_fix_after");

    // Reset held with every port requesting.
    rst_n = 1'b0;
    req   = 5'b11111;
    mode  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("rst_hold%0d", i), 5'b00000, gnt_a, id_a, val_a);
      check_output($sformatf("rst_hold_h1_%0d", i), 5'b00000, gnt_h, id_h, val_h);
      check_output($sformatf("rst_hold_p1_%0d", i), 5'b00000, {4'b0, gnt_p}, {2'b0, id_p}, val_p);
    end
    rst_n = 1'b1;
    apply_stimulus(5'b11111, 1'b1);
    check_output("rst_first", 5'b00001, gnt_a, id_a, val_a);

    foreach (vecs[k]) begin
      if (vecs[k].do_reset) do_reset();
      apply_stimulus(vecs[k].req, vecs[k].mode);
      check_output(vecs[k].name, vecs[k].exp_gnt, gnt_a, id_a, val_a);
    end

    // MAX_HOLD = 1 rotation and the single-port instance alongside it.
    rot_exp[0] = 5'b00001;
    rot_exp[1] = 5'b00010;
    rot_exp[2] = 5'b00100;
    rot_exp[3] = 5'b01000;
    rot_exp[4] = 5'b10000;
    rot_exp[5] = 5'b00001;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(5'b11111, 1'b1);
      check_output($sformatf("rot_%0d", i), rot_exp[i], gnt_h, id_h, val_h);
      check_output($sformatf("p1_req_%0d", i), 5'b00001, {4'b0, gnt_p}, {2'b0, id_p}, val_p);
    end
    apply_stimulus(5'b11110, 1'b1);
    check_output("p1_drop", 5'b00000, {4'b0, gnt_p}, {2'b0, id_p}, val_p);
    apply_stimulus(5'b00000, 1'b1);
    check_output("rot_idle", 5'b00000, gnt_h, id_h, val_h);

    // Asynchronous reset pulse between edges in the middle of a tenure.
    do_reset();
    apply_stimulus(5'b11111, 1'b1);
    check_output("mid_pre0", 5'b00001, gnt_a, id_a, val_a);
    apply_stimulus(5'b11111, 1'b1);
    check_output("mid_pre1", 5'b00001, gnt_a, id_a, val_a);
    #2;
    rst_n = 1'b0;
    #2;
    check_output("mid_async_clear", 5'b00000, gnt_a, id_a, val_a);
    #2;
    rst_n = 1'b1;
    apply_stimulus(5'b11111, 1'b1);
    check_output("mid_after_release", 5'b00001, gnt_a, id_a, val_a);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
